// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display fetch first, then a clear sequencer or a pixel writer.
// Each RAM pixel covers a 4x4 block of the 640x480 screen.
module vga_fb_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       x_coord,
    input  logic [15:0]       y_coord,
    output logic [11:0]       color_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_x,
    input  logic [6:0]        wr_y,
    input  logic [11:0]       wr_data,
    input  logic              clear_req,
    input  logic [11:0]       clear_color,
    output logic              busy,
    output logic [15:0]       drop_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [11:0]       clr_color;
    logic              fetch_d;

    logic [16:0]       tx_sum;
    logic [16:0]       tx;
    logic [16:0]       ty;
    logic              line_wrap;
    logic              fetch_slot;
    logic              wr_in_range;
    logic              wr_fire;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] wr_addr;

    // Fetch targets the pixel two clocks ahead so colour is ready at block start.
    always_comb begin
        tx_sum    = {1'b0, x_coord} + 17'd2;
        line_wrap = tx_sum >= 17'(H_TOTAL);
        tx        = line_wrap ? tx_sum - 17'(H_TOTAL) : tx_sum;
        ty        = {1'b0, y_coord};
        if (line_wrap) begin
            ty = (y_coord == 16'(V_TOTAL - 1)) ? 17'd0 : ty + 17'd1;
        end
        fetch_slot = (x_coord[1:0] == 2'b10)
                  && (tx < 17'(H_ACTIVE))
                  && (ty < 17'(V_ACTIVE));
    end

    assign fetch_addr  = ADDR_W'(ty >> 2) * ADDR_W'(FB_W) + ADDR_W'(tx >> 2);
    assign wr_addr     = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);
    assign wr_in_range = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);
    assign wr_ready    = !rst && (state == IDLE) && !fetch_slot && !clear_req;
    assign wr_fire     = wr_valid && wr_ready;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = wr_data;
        if (!rst) begin
            if (fetch_slot) begin
                mem_addr = fetch_addr;
            end else if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                mem_wdata = clr_color;
            end else if (wr_fire && wr_in_range) begin
                mem_we   = 1'b1;
                mem_addr = wr_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            clr_addr   <= '0;
            clr_color  <= '0;
            drop_count <= '0;
            color_in   <= '0;
            fetch_d    <= 1'b0;
        end else begin
            fetch_d <= fetch_slot;
            if (fetch_d) begin
                color_in <= mem_rdata;
            end
            if (wr_fire && !wr_in_range && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        clr_addr  <= '0;
                        clr_color <= clear_color;
                    end
                end
                CLEAR: begin
                    if (!fetch_slot) begin
                        clr_addr <= clr_addr + 1'b1;
                        if (clr_addr == LAST_ADDR) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: per-cycle model of slot ownership and colour timing,
// plus directed literal checks.
module tb_vga_fb_arbiter;

    localparam int FBN = 19200;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x_coord, y_coord;
    logic [11:0] color_in;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata, mem_rdata;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [11:0] wr_data;
    logic        clear_req;
    logic [11:0] clear_color;
    logic        busy;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .x_coord(x_coord), .y_coord(y_coord),
        .color_in(color_in), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .clear_req(clear_req), .clear_color(clear_color),
        .busy(busy), .drop_count(drop_count)
    );

    logic [11:0] ram [0:32767];
    bit          do_load = 1'b1;

    always @(posedge clk) begin
        if (do_load) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 12'(i);
            do_load <= 1'b0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (x=%0d y=%0d)",
                     name, act, exp, x_coord, y_coord);
        end
    endfunction

    // Model state: what the registered outputs must hold this cycle.
    bit mon_en = 1'b0;
    bit m_clr = 1'b0;
    int m_clr_n = 0, m_clr_col = 0, m_drop = 0, m_color = 0;
    bit m_pend = 1'b0;
    int m_pend_val = 0;
    int w485 = 0, nwrites = 0;

    always @(negedge clk) begin
        int  x, y, px, py, fa, nxt_col;
        bit  fetch, rdy, inr, clr_old;
        if (mon_en) begin
            x = int'(x_coord);
            y = int'(y_coord);
            if (mem_we) nwrites++;
            if (mem_we && mem_addr == 15'd485) w485++;
            chk("m_color", int'(color_in), m_color);
            chk("m_busy", int'(busy), int'(m_clr));
            chk("m_drop", int'(drop_count), m_drop);
            if (rst) begin
                chk("m_rst_ready", int'(wr_ready), 0);
                chk("m_rst_we", int'(mem_we), 0);
                m_clr = 1'b0; m_drop = 0; m_color = 0; m_pend = 1'b0;
            end else begin
                px = x + 2;
                py = y;
                if (px >= 800) begin
                    px = px - 800;
                    py = (y == 524) ? 0 : y + 1;
                end
                fetch   = (x % 4 == 2) && px < 640 && py < 480;
                nxt_col = m_pend ? m_pend_val : m_color;
                clr_old = m_clr;
                m_pend  = 1'b0;
                if (fetch) begin
                    fa = (py / 4) * 160 + px / 4;
                    chk("m_fetch_we", int'(mem_we), 0);
                    chk("m_fetch_addr", int'(mem_addr), fa);
                    chk("m_fetch_ready", int'(wr_ready), 0);
                    m_pend = 1'b1;
                    m_pend_val = int'(ram[fa]);
                end else if (m_clr) begin
                    chk("m_clr_ready", int'(wr_ready), 0);
                    chk("m_clr_we", int'(mem_we), 1);
                    chk("m_clr_addr", int'(mem_addr), m_clr_n);
                    chk("m_clr_data", int'(mem_wdata), m_clr_col);
                    m_clr_n++;
                    if (m_clr_n == FBN) m_clr = 1'b0;
                end else begin
                    rdy = !clear_req;
                    chk("m_ready", int'(wr_ready), int'(rdy));
                    inr = wr_x < 8'd160 && wr_y < 7'd120;
                    if (wr_valid && rdy && inr) begin
                        chk("m_wr_we", int'(mem_we), 1);
                        chk("m_wr_addr", int'(mem_addr),
                            int'(wr_y) * 160 + int'(wr_x));
                        chk("m_wr_data", int'(mem_wdata), int'(wr_data));
                    end else begin
                        chk("m_idle_we", int'(mem_we), 0);
                        if (wr_valid && rdy && m_drop < 65535) m_drop++;
                    end
                end
                if (!clr_old && clear_req) begin
                    m_clr = 1'b1;
                    m_clr_n = 0;
                    m_clr_col = int'(clear_color);
                end
                m_color = nxt_col;
            end
        end
    end

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (x_coord == 16'd799) begin
                x_coord = 16'd0;
                y_coord = (y_coord == 16'd524) ? 16'd0 : y_coord + 16'd1;
            end else begin
                x_coord = x_coord + 16'd1;
            end
        end
    endtask

    task automatic timeout(string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic run_to(int tx, int ty);
        int n = 0;
        while (!(int'(x_coord) == tx && int'(y_coord) == ty) && n < 2000) begin
            step(1);
            n++;
        end
        if (n >= 2000) timeout("run_to");
    endtask

    task automatic wr_do(int xx, int yy, int d);
        bit hs = 1'b0;
        wr_x = 8'(xx); wr_y = 7'(yy); wr_data = 12'(d);
        wr_valid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = wr_ready;
            step(1);
        end
        wr_valid = 1'b0;
        if (!hs) timeout("wr_handshake");
    endtask

    initial begin
        int w0, nb;
        bit found;
        rst = 1'b1; x_coord = 16'd780; y_coord = 16'd3;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        clear_req = 1'b0; clear_color = '0;
        step(1);
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_color", int'(color_in), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_we", int'(mem_we), 0);
        step(1);
        rst = 1'b0;

        run_to(798, 3);
        @(negedge clk);
        chk("wrap_addr", int'(mem_addr), 160);
        chk("wrap_we", int'(mem_we), 0);

        run_to(4, 4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("pixel_y4", int'(color_in), (i < 4) ? 161 : 162);
            step(1);
        end

        run_to(14, 4);
        w0 = w485;
        wr_do(5, 3, 'hABC);
        chk("w485_count", w485 - w0, 1);
        chk("ram485", int'(ram[485]), 'hABC);

        wr_do(160, 0, 'h111);
        chk("drop_x", int'(drop_count), 1);
        wr_do(0, 120, 'h222);
        chk("drop_y", int'(drop_count), 2);

        x_coord = 16'd790; y_coord = 16'd479;
        run_to(798, 479);
        wr_x = 8'd1; wr_y = 7'd1; wr_data = 12'h555; wr_valid = 1'b1;
        @(negedge clk);
        chk("blank_ready", int'(wr_ready), 1);
        chk("blank_we", int'(mem_we), 1);
        chk("blank_addr", int'(mem_addr), 161);
        step(1);
        wr_valid = 1'b0;
        chk("ram161", int'(ram[161]), 'h555);

        wr_x = 8'd200; wr_y = 7'd0; wr_valid = 1'b1;
        for (int i = 0; i < 70000 && drop_count != 16'hFFFF; i++) begin
            step(1);
            if (y_coord < 16'd480) y_coord = 16'd480;
        end
        step(5);
        chk("drop_sat", int'(drop_count), 'hFFFF);
        wr_valid = 1'b0;

        x_coord = 16'd0; y_coord = 16'd470;
        clear_color = 12'h0F0; clear_req = 1'b1;
        step(1);
        clear_req = 1'b0; wr_valid = 1'b1;
        @(negedge clk);
        chk("clr_busy", int'(busy), 1);
        step(100);
        clear_color = 12'hFFF; clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        for (int i = 0; i < 30000 && busy; i++) step(1);
        chk("clr_busy_end", int'(busy), 0);
        wr_valid = 1'b0;
        nb = 0;
        for (int i = 0; i < FBN; i++) if (ram[i] != 12'h0F0) nb++;
        chk("clr_bad_words", nb, 0);

        x_coord = 16'd0; y_coord = 16'd480;
        clear_color = 12'h123; clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step(1);
            #1;
            found = mem_we && mem_addr == 15'd1000;
        end
        if (!found) timeout("clr_addr_1000");
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we_now", int'(mem_we), 0);
        step(1);
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_color", int'(color_in), 0);
        chk("abort_drop", int'(drop_count), 0);
        chk("abort_we", int'(mem_we), 0);
        step(1);
        rst = 1'b0;
        w0 = nwrites;
        step(100);
        chk("abort_no_writes", nwrites - w0, 0);
        chk("ram999", int'(ram[999]), 'h123);
        chk("ram1000", int'(ram[1000]), 'h0F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
